sram_stream_reader: RTL and testbench

Read-side sequencer that sits directly downstream of the initialized SRAM block.
- On a start pulse it walks a contiguous address range in the SRAM and drives en/addr with we held low.
- It absorbs the SRAM's 1-cycle registered read latency and presents the words as a valid/ready stream with a last marker.
- Consumers are display/processing stages. Backpressure is supported with no data loss and no duplicate reads.

---
 rtl/sram_stream_reader.sv | 150 +++++++++++++++
 tb/tb_sram_stream_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_reader.sv
// Streams a contiguous SRAM range out as a valid/ready stream with a last flag.
// Optional SRAM_RD_CHECKSUM_EN adds a 16-bit sum of the streamed words.
module sram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int RAM_SIZE   = 16384
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef SRAM_RD_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued;
  logic                  pending;
  logic                  pend_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [1:0]            occ;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;

  // Occupancy counts the read still inside the SRAM pipeline.
  assign occ        = count + {1'b0, pending};
  assign out_valid  = (count != 2'd0);
  assign out_data   = fifo_data[rd_ptr];
  assign out_last   = out_valid & fifo_last[rd_ptr];
  assign pop        = out_valid & out_ready;
  assign issue      = (state == RUN) &&
                      ((occ < 2'd2) || ((occ == 2'd2) && pop));
  assign last_issue = (issued == len_q - CW'(1));
  assign next_addr  = (addr_q == ADDR_WIDTH'(RAM_SIZE - 1)) ?
                      '0 : addr_q + ADDR_WIDTH'(1);

  assign sram_en   = issue;
  assign sram_we   = 1'b0;
  assign sram_addr = addr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      issued       <= '0;
      pending      <= 1'b0;
      pend_last    <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= '0;
    end else begin
      done      <= 1'b0;
      pending   <= issue;
      pend_last <= issue && last_issue;
      if (issue) begin
        addr_q <= next_addr;
        issued <= issued + CW'(1);
      end
      if (pending) begin
        fifo_data[wr_ptr] <= sram_data_i;
        fifo_last[wr_ptr] <= pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, pending} - {1'b0, pop};
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= length;
            addr_q <= base_addr;
            issued <= '0;
            busy   <= 1'b1;
            if (length == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_RD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (start && state == IDLE) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + 16'(out_data);
    end
  end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed and randomized checks of sram_stream_reader against an
// address-arithmetic reference over a behavioural registered-read SRAM.
module tb_sram_stream_reader;

  localparam int DW  = 8;
  localparam int AW  = 14;
  localparam int RAM = 16384;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef SRAM_RD_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  logic [7:0] img [RAM];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_SIZE(RAM)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .sram_en(sram_en),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_data_i(sram_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
`ifdef SRAM_RD_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always @(posedge clk) begin
    if (sram_en && !sram_we) sram_rdata <= img[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[cyc % 6];
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic xfer(input int base, input int len, input int mode,
                      input bit inject);
    int issues, accepts, first_v, last_acc, done_cyc, sum;
    logic pv, pr, pl;
    logic [7:0] pd;
    @(negedge clk);
    start = 1'b1;
    base_addr = AW'(base);
    length = (AW+1)'(len);
    out_ready = rdy(mode, 0);
    #1;
    chk("busy_pre", 32'(busy), 0);
    issues = 0; accepts = 0; first_v = -1; last_acc = -1;
    done_cyc = -1; sum = 0; pv = 0; pr = 0; pd = 0; pl = 0;
    for (int cyc = 1; cyc <= len * 8 + 20 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = inject && cyc == 2;
      if (inject && cyc == 2) begin
        base_addr = 14'h0100;
        length = 15'd8;
      end
      out_ready = rdy(mode, cyc);
      #1;
      if (pv && !pr) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(pd));
        chk("hold_last", 32'(out_last), 32'(pl));
      end
      if (sram_en) begin
        chk("addr", 32'(sram_addr), (base + issues) % RAM);
        chk("we", 32'(sram_we), 0);
        issues++;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        chk("data", 32'(out_data), 32'(img[(base + accepts) % RAM]));
        chk("last", 32'(out_last), 32'(accepts == len - 1));
        sum += out_data;
        accepts++;
        last_acc = cyc;
      end
      chk("ahead", 32'(issues - accepts <= 2), 1);
      if (done) begin
        done_cyc = cyc;
        chk("busy_done", 32'(busy), 1);
`ifdef SRAM_RD_CHECKSUM_EN
        chk("checksum", 32'(checksum), sum % 65536);
`endif
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc > 0), 1);
    chk("words", accepts, len);
    chk("issues", issues, len);
    if (len == 0) chk("done_len0", done_cyc, 1);
    else chk("done_after_last", done_cyc, last_acc + 1);
    if (mode == 0 && len > 0) chk("latency", first_v, 3);
    @(negedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < RAM; i++) img[i] = i[7:0];
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(sram_en), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    reset_n = 1'b1;

    xfer(16'h0010, 4, 0, 0);
    xfer(16'h0010, 4, 1, 0);
    xfer(16'h3FFE, 4, 0, 0);
    xfer(0, 0, 0, 0);
    xfer(16'h0010, 4, 0, 1);
    xfer(16'h0010, 4, 2, 0);
    xfer(16'h00F0, 16, 0, 0);

    // Abort after two accepted words, then confirm a clean restart.
    @(negedge clk);
    start = 1'b1; base_addr = '0; length = 15'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      #1;
      if (out_valid && out_ready) acc++;
      if (acc < 2) @(negedge clk);
    end
    chk("abort_acc", acc, 2);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_en", 32'(sram_en), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_last", 32'(out_last), 0);
    chk("abort_addr", 32'(sram_addr), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("abort_nodone", 32'(done), 0);
      chk("abort_novalid", 32'(out_valid), 0);
    end
    xfer(0, 2, 0, 0);

    for (int i = 0; i < RAM; i++) img[i] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      xfer(int'($urandom % RAM), int'($urandom_range(1, 24)),
           int'($urandom % 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
